// File: rtl/mul_ctrl_pkg.sv
// Package: mul_ctrl_pkg
// Shared types for the RV32M multiply issue controller.
//   mul_op_e : funct3[1:0] encoding of MUL/MULH/MULHSU/MULHU
//   state_e  : controller states IDLE/CALC/DONE
//   op_signs : {sign1,sign2} operand sign controls for an op
//   op_high  : 1 when the op returns product[63:32]
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [1:0] op_signs(input mul_op_e op);
    case (op)
      MULH:    return 2'b11;
      MULHSU:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic op_high(input mul_op_e op);
    return (op != MUL);
  endfunction

endpackage

// File: rtl/Mul_32x32.sv
// Module: Mul_32x32
// Combinational radix-4 Booth 32x32 multiplier with per-operand sign control.
// Ports:
//   src1, src2   in  32  operands
//   sign1, sign2 in  1   treat src1/src2 as signed when 1
//   simd         in  1   enable the 4x byte-lane products on dst_1..dst_4
//   dst64        out 64  full product
//   dst_1..dst_4 out 16  unsigned byte-lane products (zero when simd=0)
module Mul_32x32 (
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        sign1,
  input  logic        sign2,
  input  logic        simd,
  output logic [63:0] dst64,
  output logic [15:0] dst_1,
  output logic [15:0] dst_2,
  output logic [15:0] dst_3,
  output logic [15:0] dst_4
);

  logic [32:0] a33;
  logic [32:0] b33;
  logic [63:0] a_ext;
  logic [34:0] bx;
  logic [2:0]  trip;
  logic [63:0] pp;
  logic [63:0] acc;

  // Operands become 33-bit signed values; sign controls choose sign/zero extension.
  assign a33 = {sign1 & src1[31], src1};
  assign b33 = {sign2 & src2[31], src2};

  // Booth recoding over b33 extended to 34 bits; bx[0] is the implicit b[-1]=0.
  // Accumulation is mod 2^64, which is exact for the low 64 product bits.
  always_comb begin
    a_ext = {{31{a33[32]}}, a33};
    bx    = {b33[32], b33, 1'b0};
    acc   = '0;
    trip  = '0;
    pp    = '0;
    for (int unsigned i = 0; i < 17; i++) begin
      trip = bx[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
  end

  assign dst64 = acc;

  assign dst_1 = simd ? ({8'h00, src1[7:0]}   * {8'h00, src2[7:0]})   : '0;
  assign dst_2 = simd ? ({8'h00, src1[15:8]}  * {8'h00, src2[15:8]})  : '0;
  assign dst_3 = simd ? ({8'h00, src1[23:16]} * {8'h00, src2[23:16]}) : '0;
  assign dst_4 = simd ? ({8'h00, src1[31:24]} * {8'h00, src2[31:24]}) : '0;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Module: mul_issue_ctrl
// Sequences Mul_32x32 for RV32M MUL/MULH/MULHSU/MULHU between issue and writeback.
// Accept in cycle N -> resp_valid in N+2 (N+1 on a reuse hit).
// Ports:
//   clk, rst_n (async active-low), flush (kills in-flight op)
//   req_valid/req_ready, req_op[1:0], req_src1, req_src2, req_tag[TAG_W]
//   resp_valid/resp_ready, resp_data[32], resp_tag[TAG_W], busy
// Optional feature: define MUL_REUSE_EN to keep the last computed product and
// return it without a CALC cycle when operands (and relevant signs) match.
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  if (XLEN != 32) begin : g_xlen_check
    $error("mul_issue_ctrl: only XLEN=32 is supported");
  end

  state_e           state_q, state_d;
  logic [XLEN-1:0]  src1_q, src1_d;
  logic [XLEN-1:0]  src2_q, src2_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  logic             high_q, high_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  mul_op_e          req_op_e;
  logic             accept;
  logic [63:0]      product;
  logic [15:0]      lane_unused_1, lane_unused_2, lane_unused_3, lane_unused_4;

`ifdef MUL_REUSE_EN
  logic             cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]  cache_src1_q, cache_src1_d;
  logic [XLEN-1:0]  cache_src2_q, cache_src2_d;
  logic [1:0]       cache_signs_q, cache_signs_d;
  logic [63:0]      cache_prod_q, cache_prod_d;
  logic             cache_hit;

  // The low half is sign-independent, so MUL hits regardless of cached signs.
  assign cache_hit = cache_valid_q
                   & (req_src1 == cache_src1_q)
                   & (req_src2 == cache_src2_q)
                   & ((op_signs(req_op_e) == cache_signs_q) | (req_op_e == MUL));
`endif

  assign req_op_e   = mul_op_e'(req_op);
  assign req_ready  = ~flush & ((state_q == IDLE) | ((state_q == DONE) & resp_ready));
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

  // Multiplier sees only the operand registers, never req_* directly.
  Mul_32x32 u_mul (
    .src1  (src1_q),
    .src2  (src2_q),
    .sign1 (sign1_q),
    .sign2 (sign2_q),
    .simd  (1'b0),
    .dst64 (product),
    .dst_1 (lane_unused_1),
    .dst_2 (lane_unused_2),
    .dst_3 (lane_unused_3),
    .dst_4 (lane_unused_4)
  );

  always_comb begin
    state_d     = state_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    sign1_d     = sign1_q;
    sign2_d     = sign2_q;
    high_d      = high_q;
    tag_d       = tag_q;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;
`ifdef MUL_REUSE_EN
    cache_valid_d = cache_valid_q;
    cache_src1_d  = cache_src1_q;
    cache_src2_d  = cache_src2_q;
    cache_signs_d = cache_signs_q;
    cache_prod_d  = cache_prod_q;
`endif

    // accept already excludes flush, and only occurs in IDLE or in DONE with
    // a same-cycle response handshake, so it owns the transition when present.
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d            = CALC;
      src1_d             = req_src1;
      src2_d             = req_src2;
      {sign1_d, sign2_d} = op_signs(req_op_e);
      high_d             = op_high(req_op_e);
      tag_d              = req_tag;
`ifdef MUL_REUSE_EN
      if (cache_hit) begin
        state_d     = DONE;
        resp_data_d = op_high(req_op_e) ? cache_prod_q[63:32] : cache_prod_q[31:0];
        resp_tag_d  = req_tag;
      end
`endif
    end else begin
      case (state_q)
        CALC: begin
          state_d     = DONE;
          resp_data_d = high_q ? product[63:32] : product[31:0];
          resp_tag_d  = tag_q;
`ifdef MUL_REUSE_EN
          cache_valid_d = 1'b1;
          cache_src1_d  = src1_q;
          cache_src2_d  = src2_q;
          cache_signs_d = {sign1_q, sign2_q};
          cache_prod_d  = product;
`endif
        end
        DONE: begin
          if (resp_ready) state_d = IDLE;
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src1_q      <= '0;
      src2_q      <= '0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      high_q      <= 1'b0;
      tag_q       <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      sign1_q     <= sign1_d;
      sign2_q     <= sign2_d;
      high_q      <= high_d;
      tag_q       <= tag_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

`ifdef MUL_REUSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_src1_q  <= '0;
      cache_src2_q  <= '0;
      cache_signs_q <= '0;
      cache_prod_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_src1_q  <= cache_src1_d;
      cache_src2_q  <= cache_src2_d;
      cache_signs_q <= cache_signs_d;
      cache_prod_q  <= cache_prod_d;
    end
  end
`endif

endmodule
